// File: rtl/alu_arb.sv
// Two-requester front end to a single shared 4-bit ALU.
// One operation is in flight at a time: IDLE grants, EXEC computes, RESP holds the answer.
module alu_arb #(
   parameter int RR_EN = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [2:0] req0_op,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [2:0] req1_op,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic       resp_id,
   output logic [3:0] resp_result,
   output logic       resp_cout,
   output logic       resp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       last_grant;
   logic       grant_id;
   logic       accept;

   logic [2:0] cap_op;
   logic [3:0] cap_a;
   logic [3:0] cap_b;
   logic       cap_id;

   logic [3:0] res_q;
   logic       cout_q;
   logic       err_q;
   logic       id_q;

   logic [4:0] sum5;
   logic [3:0] alu_res;
   logic       alu_cout;
   logic       alu_err;

   // A lone requester always wins; contention goes to the other side of the last grant
   // in round-robin mode, otherwise to requester 0.
   always_comb begin
      grant_id = ~req0_valid;
      if (req0_valid && req1_valid) begin
         grant_id = (RR_EN != 0) ? ~last_grant : 1'b0;
      end
   end

   // Ready is gated by rst_n so nothing reports acceptance while reset is held.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if ((req0_valid || req1_valid) && rst_n) begin
               accept     = 1'b1;
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_nxt  = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sum5     = {1'b0, cap_a} + {1'b0, cap_b};
      alu_res  = 4'd0;
      alu_cout = 1'b0;
      alu_err  = 1'b0;
      case (cap_op)
         3'b000: begin
            alu_res  = sum5[3:0];
            alu_cout = sum5[4];
         end
         3'b001:  alu_res = cap_a - cap_b;
         3'b010:  alu_res = cap_a & cap_b;
         3'b011:  alu_res = cap_a | cap_b;
         3'b100:  alu_res = cap_a ^ cap_b;
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cap_op     <= 3'd0;
         cap_a      <= 4'd0;
         cap_b      <= 4'd0;
         cap_id     <= 1'b0;
         res_q      <= 4'd0;
         cout_q     <= 1'b0;
         err_q      <= 1'b0;
         id_q       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            last_grant <= grant_id;
            cap_id     <= grant_id;
            cap_op     <= grant_id ? req1_op : req0_op;
            cap_a      <= grant_id ? req1_a : req0_a;
            cap_b      <= grant_id ? req1_b : req0_b;
         end
         if (state == EXEC) begin
            res_q  <= alu_res;
            cout_q <= alu_cout;
            err_q  <= alu_err;
            id_q   <= cap_id;
         end
      end
   end

   assign resp_valid  = (state == RESP);
   assign resp_id     = id_q;
   assign resp_result = res_q;
   assign resp_cout   = cout_q;
   assign resp_err    = err_q;

endmodule

// File: tb/tb_alu_arb.sv
// Drives a round-robin and a fixed-priority alu_arb with identical inputs and checks
// both against a transaction-level model every cycle, plus directed literal checks.
module tb_alu_arb;

   logic       clk;
   logic       rst_n;
   logic       req0_valid;
   logic [2:0] req0_op;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic       req1_valid;
   logic [2:0] req1_op;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic       resp_ready;

   logic       rdy0  [2];
   logic       rdy1  [2];
   logic       rv    [2];
   logic       rid   [2];
   logic [3:0] rres  [2];
   logic       rcout [2];
   logic       rerr  [2];

   int checks   = 0;
   int failures = 0;

   bit         busy    [2];
   int         age     [2];
   bit         lastG   [2];
   bit         expId   [2];
   logic [5:0] expResp [2];
   int         grantLog [2][64];
   int         grantCnt [2];

   alu_arb #(.RR_EN(1)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_id(rid[0]),
      .resp_result(rres[0]), .resp_cout(rcout[0]), .resp_err(rerr[0])
   );

   alu_arb #(.RR_EN(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_id(rid[1]),
      .resp_result(rres[1]), .resp_cout(rcout[1]), .resp_err(rerr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU in plain integer arithmetic, packed as {err, cout, result}.
   function automatic logic [5:0] aluRef(input int op, input int a, input int b);
      int s;
      case (op)
         0: begin
            s = a + b;
            aluRef = {1'b0, 1'(s / 16), 4'(s % 16)};
         end
         1:       aluRef = {2'b00, 4'((a - b + 16) % 16)};
         2:       aluRef = {2'b00, 4'(a & b)};
         3:       aluRef = {2'b00, 4'(a | b)};
         4:       aluRef = {2'b00, 4'(a ^ b)};
         default: aluRef = 6'b10_0000;
      endcase
   endfunction

   // Instance 0 is round-robin, instance 1 fixed priority.
   task automatic modelStep(input int k);
      bit g;
      if (!rst_n) begin
         checkOutput("rst_ready0", 32'(rdy0[k]), 0);
         checkOutput("rst_ready1", 32'(rdy1[k]), 0);
         checkOutput("rst_valid", 32'(rv[k]), 0);
         checkOutput("rst_fields", {rid[k], rres[k], rcout[k], rerr[k]}, 0);
         busy[k]  = 1'b0;
         lastG[k] = 1'b1;
         return;
      end
      if (!busy[k]) begin
         if (req0_valid && req1_valid) g = (k == 0) ? !lastG[k] : 1'b0;
         else g = !req0_valid;
         checkOutput("grant_ready0", 32'(rdy0[k]), 32'(req0_valid && !g));
         checkOutput("grant_ready1", 32'(rdy1[k]), 32'(req1_valid && g));
         checkOutput("idle_valid", 32'(rv[k]), 0);
         if (req0_valid || req1_valid) begin
            busy[k]  = 1'b1;
            age[k]   = 0;
            lastG[k] = g;
            expId[k] = g;
            expResp[k] = g ? aluRef(int'(req1_op), int'(req1_a), int'(req1_b))
                           : aluRef(int'(req0_op), int'(req0_a), int'(req0_b));
            if (grantCnt[k] < 64) grantLog[k][grantCnt[k]] = int'(g);
            grantCnt[k]++;
         end
      end else begin
         age[k]++;
         checkOutput("busy_ready0", 32'(rdy0[k]), 0);
         checkOutput("busy_ready1", 32'(rdy1[k]), 0);
         if (age[k] == 1) begin
            checkOutput("exec_valid", 32'(rv[k]), 0);
         end else begin
            checkOutput("resp_valid", 32'(rv[k]), 1);
            checkOutput("resp_id", 32'(rid[k]), 32'(expId[k]));
            checkOutput("resp_fields", {rerr[k], rcout[k], rres[k]}, 32'(expResp[k]));
            if (resp_ready) busy[k] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) modelStep(k);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input bit v0, input logic [2:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                                input bit v1, input logic [2:0] op1, input logic [3:0] a1, input logic [3:0] b1);
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
   endtask

   int base0;
   int base1;

   initial begin
      rst_n      = 1'b0;
      resp_ready = 1'b1;
      applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
      for (int k = 0; k < 2; k++) begin
         busy[k] = 0; age[k] = 0; lastG[k] = 1; grantCnt[k] = 0;
      end

      checkOutput("model_add", 32'(aluRef(0, 9, 8)), 32'h11);
      checkOutput("model_sub", 32'(aluRef(1, 3, 5)), 32'h0E);
      checkOutput("model_and", 32'(aluRef(2, 12, 10)), 32'h08);
      checkOutput("model_illegal", 32'(aluRef(6, 5, 3)), 32'h20);

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Continuous contention: four grants per instance.
      base0 = grantCnt[0];
      base1 = grantCnt[1];
      applyStimulus(1, 3'd0, 4'd7, 4'd5, 1, 3'd2, 4'hC, 4'hA);
      repeat (12) cyc();
      applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
      checkOutput("rr_grant_count", 32'(grantCnt[0] - base0), 4);
      checkOutput("fp_grant_count", 32'(grantCnt[1] - base1), 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("rr_grant_seq", 32'(grantLog[0][base0 + i]), 32'(i % 2));
         checkOutput("fp_grant_seq", 32'(grantLog[1][base1 + i]), 0);
      end

      // req0 add 9+8 -> 1 with carry.
      applyStimulus(1, 3'd0, 4'd9, 4'd8, 0, 3'd0, 4'd0, 4'd0);
      @(negedge clk);
      checkOutput("add_ready0", 32'(rdy0[0]), 1);
      cyc();
      applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
      @(negedge clk);
      checkOutput("add_c1_valid", 32'(rv[0]), 0);
      cyc();
      @(negedge clk);
      checkOutput("add_c2_valid", 32'(rv[0]), 1);
      checkOutput("add_id", 32'(rid[0]), 0);
      checkOutput("add_result", 32'(rres[0]), 1);
      checkOutput("add_cout", 32'(rcout[0]), 1);
      checkOutput("add_err", 32'(rerr[0]), 0);
      cyc();

      // req1 sub 3-5 with the consumer stalled for four cycles.
      resp_ready = 1'b0;
      applyStimulus(0, 3'd0, 4'd0, 4'd0, 1, 3'd1, 4'd3, 4'd5);
      @(negedge clk);
      checkOutput("sub_ready1", 32'(rdy1[0]), 1);
      cyc();
      cyc();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("stall_valid", 32'(rv[0]), 1);
         checkOutput("stall_result", 32'(rres[0]), 14);
         checkOutput("stall_cout", 32'(rcout[0]), 0);
         checkOutput("stall_ready1", 32'(rdy1[0]), 0);
         cyc();
      end
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("release_ready1", 32'(rdy1[0]), 0);
      cyc();
      applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
      cyc();

      // Illegal opcode.
      applyStimulus(1, 3'b110, 4'd5, 4'd3, 0, 3'd0, 4'd0, 4'd0);
      cyc();
      applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
      cyc();
      @(negedge clk);
      checkOutput("ill_valid", 32'(rv[0]), 1);
      checkOutput("ill_result", 32'(rres[0]), 0);
      checkOutput("ill_cout", 32'(rcout[0]), 0);
      checkOutput("ill_err", 32'(rerr[0]), 1);
      cyc();

      // Reset during EXEC discards the op and restores the pointer.
      applyStimulus(1, 3'd0, 4'd1, 4'd1, 0, 3'd0, 4'd0, 4'd0);
      cyc();
      applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_exec_valid", 32'(rv[0]), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("post_rst_valid", 32'(rv[0]), 0);
         cyc();
      end
      applyStimulus(1, 3'd2, 4'hF, 4'h3, 1, 3'd3, 4'h1, 4'h2);
      @(negedge clk);
      checkOutput("post_rst_ready0", 32'(rdy0[0]), 1);
      checkOutput("post_rst_ready1", 32'(rdy1[0]), 0);
      cyc();
      applyStimulus(0, 3'd0, 4'd0, 4'd0, 0, 3'd0, 4'd0, 4'd0);
      repeat (4) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
